// File: rtl/vga_plot_sink_if.sv
// Pixel plot bus between a rasterizer (circle/line drawer) and the plot sink.
// The sink applies back-pressure through plot_ready.
interface vga_plot_sink_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       plot_ready;

  modport master (output vga_x, vga_y, vga_colour, vga_plot, input plot_ready);
  modport slave  (input vga_x, vga_y, vga_colour, vga_plot, output plot_ready);
endinterface

// File: rtl/vga_plot_sink.sv
// Plot sink: clips off-screen pixels, queues accepted plots in a FIFO, writes them
// to a stallable framebuffer port, and performs full-screen clears.
module vga_plot_sink #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  vga_plot_sink_if.slave    pix,
  input  logic              clear_start,
  input  logic [2:0]        clear_colour,
  output logic              clear_done,
  output logic              busy,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_wait,
  output logic [7:0]        clip_count,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR_DRAIN,
    S_CLEAR,
    S_CLR_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  state_t            state_q, state_d;
  pix_t              mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [7:0]        clip_q, clip_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [2:0]        colour_q, colour_d;

  logic              empty, full, in_idle, drain_en;
  logic              ready, accept, clipped, push, pop;
  pix_t              head;
  logic [ADDR_W-1:0] head_addr;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign in_idle  = (state_q == S_IDLE);
  assign drain_en = (state_q == S_IDLE) || (state_q == S_CLR_DRAIN);

  assign ready    = !rst && in_idle && !full;
  assign accept   = pix.vga_plot && ready;
  assign clipped  = (32'(pix.vga_x) >= WIDTH) || (32'(pix.vga_y) >= HEIGHT);
  assign push     = accept && !clipped;
  assign pop      = fb_we && !fb_wait && drain_en;

  assign head      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_addr = ADDR_W'(head.y) * ADDR_W'(WIDTH) + ADDR_W'(head.x);

  assign pix.plot_ready = ready;
  assign busy           = !rst && (!in_idle || !empty);
  assign clip_count     = rst ? '0 : clip_q;
  assign overflow       = !rst && ovf_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (clear_start) state_d = S_CLR_DRAIN;
      S_CLR_DRAIN: if (empty) state_d = S_CLEAR;
      S_CLEAR:     if (!fb_wait && (cnt_q == LAST_ADDR)) state_d = S_CLR_DONE;
      S_CLR_DONE:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs; address and data are combinational from held state, so they stay stable across stalls
  always_comb begin
    fb_we      = 1'b0;
    fb_addr    = head_addr;
    fb_data    = head.c;
    clear_done = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE, S_CLR_DRAIN: fb_we = !empty;
        S_CLEAR: begin
          fb_we   = 1'b1;
          fb_addr = cnt_q;
          fb_data = colour_q;
        end
        S_CLR_DONE: clear_done = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
    clip_d   = (accept && clipped && (clip_q != '1)) ? clip_q + 8'd1 : clip_q;
    ovf_d    = ovf_q || (pix.vga_plot && !ready);
    colour_d = (in_idle && clear_start) ? clear_colour : colour_q;
    cnt_d    = cnt_q;
    if (state_q == S_CLR_DRAIN) begin
      cnt_d = '0;
    end else if ((state_q == S_CLEAR) && !fb_wait) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      clip_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      colour_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      clip_q   <= clip_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      colour_q <= colour_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= '{x: pix.vga_x, y: pix.vga_y, c: pix.vga_colour};
    end
  end

endmodule

// File: tb/tb_vga_plot_sink.sv
// Self-checking bench for vga_plot_sink: directed scenarios plus a randomized
// plot stream checked against a queue-based reference model.
module tb_vga_plot_sink;
  localparam int unsigned W  = 160;
  localparam int unsigned H  = 120;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_start;
  logic [2:0]    clear_colour;
  logic          clear_done;
  logic          busy;
  logic [AW-1:0] fb_addr;
  logic [2:0]    fb_data;
  logic          fb_we;
  logic          fb_wait;
  logic [7:0]    clip_count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  d;
  } exp_t;

  always #5 clk = ~clk;

  vga_plot_sink_if pix();

  vga_plot_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix(pix),
    .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
    .busy(busy), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .fb_wait(fb_wait), .clip_count(clip_count), .overflow(overflow)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix.vga_plot = 1'b0; pix.vga_x = '0; pix.vga_y = '0; pix.vga_colour = '0;
    clear_start = 1'b0; clear_colour = '0; fb_wait = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL rst_fb_we: got %b expected 0", fb_we); end
    n_checks++; if (pix.plot_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", pix.plot_ready); end
    n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", clear_done); end
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (pix.plot_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", pix.plot_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
    n_checks++; if (clip_count !== 8'd0) begin n_fail++; $display("FAIL post_rst_clip: got %0d expected 0", clip_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL post_rst_ovf: got %b expected 0", overflow); end
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_we: got %b expected 0", fb_we); end
    adv();
  endtask

  task automatic test_latency();
    int unsigned ea;
    do_reset();
    pix.vga_x = 8'd80; pix.vga_y = 7'd60; pix.vga_colour = 3'd4; pix.vga_plot = 1'b1;
    ea = 60 * W + 80;
    @(negedge clk);
    n_checks++; if (pix.plot_ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %b expected 1", pix.plot_ready); end
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL lat_we_early: got %b expected 0", fb_we); end
    adv();
    pix.vga_plot = 1'b0;
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b1) begin n_fail++; $display("FAIL lat_we: got %b expected 1", fb_we); end
    n_checks++; if (32'(fb_addr) !== ea) begin n_fail++; $display("FAIL lat_addr: got %0d expected %0d", fb_addr, ea); end
    n_checks++; if (fb_data !== 3'd4) begin n_fail++; $display("FAIL lat_data: got %0d expected 4", fb_data); end
    adv();
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL lat_we_after: got %b expected 0", fb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_after: got %b expected 0", busy); end
    adv();
  endtask

  task automatic test_clip();
    int unsigned exp_clip;
    int          we_seen;
    do_reset();
    we_seen = 0;
    pix.vga_plot = 1'b1; pix.vga_x = 8'd160; pix.vga_y = 7'd0; pix.vga_colour = 3'd2;
    adv();
    pix.vga_x = 8'd0; pix.vga_y = 7'd120;
    adv();
    pix.vga_plot = 1'b0;
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL clip_we: got %b expected 0", fb_we); end
    n_checks++; if (clip_count !== 8'd2) begin n_fail++; $display("FAIL clip_two: got %0d expected 2", clip_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clip_ovf: got %b expected 0", overflow); end
    exp_clip = 2;
    adv();
    for (int i = 0; i < 300; i++) begin
      pix.vga_plot = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        pix.vga_x = 8'($urandom_range(160, 255)); pix.vga_y = 7'($urandom_range(0, 127));
      end else begin
        pix.vga_x = 8'($urandom_range(0, 255));   pix.vga_y = 7'($urandom_range(120, 127));
      end
      @(negedge clk);
      if (fb_we) we_seen++;
      adv();
      if (exp_clip < 255) exp_clip++;
    end
    pix.vga_plot = 1'b0;
    @(negedge clk);
    n_checks++; if (clip_count !== 8'(exp_clip)) begin n_fail++; $display("FAIL clip_sat: got %0d expected %0d", clip_count, exp_clip); end
    n_checks++; if (we_seen !== 0) begin n_fail++; $display("FAIL clip_no_write: got %0d writes expected 0", we_seen); end
    adv();
  endtask

  task automatic test_backpressure();
    logic [2:0] cv;
    do_reset();
    fb_wait = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cv = 3'(i);
      pix.vga_plot = 1'b1; pix.vga_x = 8'(i); pix.vga_y = 7'd0; pix.vga_colour = cv;
      @(negedge clk);
      n_checks++; if (pix.plot_ready !== (i < 8)) begin n_fail++; $display("FAIL bp_ready_%0d: got %b expected %b", i, pix.plot_ready, (i < 8)); end
      adv();
    end
    pix.vga_plot = 1'b0;
    @(negedge clk);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b expected 1", overflow); end
    n_checks++; if (fb_we !== 1'b1 || fb_addr !== '0) begin n_fail++; $display("FAIL bp_hold: got we=%b addr=%0d expected we=1 addr=0", fb_we, fb_addr); end
    adv();
    fb_wait = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cv = 3'(k);
      @(negedge clk);
      n_checks++;
      if (fb_we !== 1'b1 || 32'(fb_addr) !== k || fb_data !== cv) begin
        n_fail++; $display("FAIL bp_write_%0d: got we=%b addr=%0d data=%0d expected we=1 addr=%0d data=%0d", k, fb_we, fb_addr, fb_data, k, cv);
      end
      adv();
    end
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL bp_ninth_dropped: got we=%b addr=%0d expected we=0", fb_we, fb_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy: got %b expected 0", busy); end
    adv();
  endtask

  task automatic test_random();
    exp_t        mq[$];
    int unsigned exp_clip;
    logic        exp_ovf, exp_ready;
    int          guard;
    do_reset();
    exp_clip = 0; exp_ovf = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc < 600) begin
        pix.vga_plot   = ($urandom_range(0, 2) != 0);
        pix.vga_x      = 8'($urandom_range(0, 175));
        pix.vga_y      = 7'($urandom_range(0, 127));
        pix.vga_colour = 3'($urandom);
        fb_wait        = ($urandom_range(0, 3) == 0);
      end else begin
        pix.vga_plot = 1'b0;
        fb_wait      = ($urandom_range(0, 3) == 0);
        if (mq.size() == 0) break;
      end
      @(negedge clk);
      exp_ready = (mq.size() < D);
      n_checks++; if (pix.plot_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, pix.plot_ready, exp_ready); end
      n_checks++; if (fb_we !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_we@%0d: got %b expected %b", cyc, fb_we, (mq.size() != 0)); end
      n_checks++; if (busy !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, (mq.size() != 0)); end
      n_checks++; if (clip_count !== 8'(exp_clip)) begin n_fail++; $display("FAIL rnd_clip@%0d: got %0d expected %0d", cyc, clip_count, exp_clip); end
      n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b expected %b", cyc, overflow, exp_ovf); end
      if (mq.size() != 0) begin
        n_checks++;
        if (32'(fb_addr) !== mq[0].a || fb_data !== mq[0].d) begin
          n_fail++; $display("FAIL rnd_write@%0d: got addr=%0d data=%0d expected addr=%0d data=%0d", cyc, fb_addr, fb_data, mq[0].a, mq[0].d);
        end
        if (!fb_wait) void'(mq.pop_front());
      end
      if (pix.vga_plot) begin
        if (!exp_ready) exp_ovf = 1'b1;
        else if (32'(pix.vga_x) >= W || 32'(pix.vga_y) >= H) begin
          if (exp_clip < 255) exp_clip++;
        end else mq.push_back('{a: 32'(pix.vga_y) * W + 32'(pix.vga_x), d: pix.vga_colour});
      end
      adv();
    end
    guard = mq.size();
    n_checks++; if (guard !== 0) begin n_fail++; $display("FAIL rnd_drain_timeout: got %0d pending expected 0", guard); end
  endtask

  task automatic test_clear();
    int unsigned nw, bad, ready_hi, done;
    do_reset();
    clear_colour = 3'd1; clear_start = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy_before: got %b expected 0", busy); end
    adv();
    clear_start = 1'b0; clear_colour = 3'd5;
    nw = 0; bad = 0; ready_hi = 0; done = 0;
    for (int cyc = 0; cyc < 40000 && done == 0; cyc++) begin
      fb_wait = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (pix.plot_ready) ready_hi++;
      if (!busy) bad++;
      if (clear_done) begin
        done++;
        if (fb_we) bad++;
      end else if (fb_we) begin
        if (32'(fb_addr) !== nw || fb_data !== 3'd1) bad++;
        if (!fb_wait) nw++;
      end
      adv();
    end
    fb_wait = 1'b0;
    n_checks++; if (done !== 1) begin n_fail++; $display("FAIL clr_done_seen: got %0d expected 1", done); end
    n_checks++; if (nw !== W * H) begin n_fail++; $display("FAIL clr_writes: got %0d expected %0d", nw, W * H); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clr_order_data: got %0d bad cycles expected 0", bad); end
    n_checks++; if (ready_hi !== 0) begin n_fail++; $display("FAIL clr_ready_low: got %0d ready cycles expected 0", ready_hi); end
    @(negedge clk);
    n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL clr_done_width: got %b expected 0", clear_done); end
    n_checks++; if (pix.plot_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_after: got %b expected 1", pix.plot_ready); end
    n_checks++; if (busy !== 1'b0 || fb_we !== 1'b0) begin n_fail++; $display("FAIL clr_idle_after: got busy=%b we=%b expected 0 0", busy, fb_we); end
    adv();
  endtask

  task automatic test_clear_behind();
    exp_t        px[3];
    int unsigned nw, bad, done;
    logic        tried;
    do_reset();
    fb_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix.vga_plot = 1'b1;
      pix.vga_x = 8'($urandom_range(0, W - 1)); pix.vga_y = 7'($urandom_range(0, H - 1));
      pix.vga_colour = 3'($urandom);
      px[i] = '{a: 32'(pix.vga_y) * W + 32'(pix.vga_x), d: pix.vga_colour};
      adv();
    end
    pix.vga_plot = 1'b0;
    clear_start = 1'b1; clear_colour = 3'd6;
    adv();
    clear_start = 1'b0; fb_wait = 1'b0;
    nw = 0; bad = 0; done = 0; tried = 1'b0;
    for (int cyc = 0; cyc < 25000 && done == 0; cyc++) begin
      if (nw == 10 && !tried) begin
        pix.vga_plot = 1'b1; pix.vga_x = 8'd1; pix.vga_y = 7'd1; pix.vga_colour = 3'd7;
        tried = 1'b1;
        @(negedge clk);
        n_checks++; if (pix.plot_ready !== 1'b0) begin n_fail++; $display("FAIL cb_ready_in_clear: got %b expected 0", pix.plot_ready); end
      end else begin
        pix.vga_plot = 1'b0;
        @(negedge clk);
      end
      if (clear_done) done++;
      else if (fb_we) begin
        if (nw < 3) begin
          if (32'(fb_addr) !== px[nw].a || fb_data !== px[nw].d) bad++;
        end else if (32'(fb_addr) !== nw - 3 || fb_data !== 3'd6) bad++;
        nw++;
      end
      adv();
    end
    pix.vga_plot = 1'b0;
    n_checks++; if (done !== 1) begin n_fail++; $display("FAIL cb_done_seen: got %0d expected 1", done); end
    n_checks++; if (nw !== W * H + 3) begin n_fail++; $display("FAIL cb_writes: got %0d expected %0d", nw, W * H + 3); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL cb_order: got %0d bad writes expected 0", bad); end
    @(negedge clk);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL cb_ovf: got %b expected 1", overflow); end
    adv();
  endtask

  task automatic test_reset_mid_clear();
    logic hit;
    int   we_cnt, done_cnt;
    do_reset();
    pix.vga_plot = 1'b1; pix.vga_x = 8'd200; pix.vga_y = 7'd3;
    adv();
    pix.vga_x = 8'd5;
    clear_start = 1'b1; clear_colour = 3'd3;
    adv();
    clear_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (fb_we && 32'(fb_addr) == 500) hit = 1'b1;
      else adv();
    end
    pix.vga_plot = 1'b0;
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rmc_reach_500: got %b expected 1", hit); end
    n_checks++; if (clip_count !== 8'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL rmc_pre_state: got clip=%0d ovf=%b expected 1 1", clip_count, overflow); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL rmc_we_in_rst: got %b expected 0", fb_we); end
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL rmc_we_after: got %b expected 0", fb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy: got %b expected 0", busy); end
    n_checks++; if (pix.plot_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_ready: got %b expected 1", pix.plot_ready); end
    n_checks++; if (clip_count !== 8'd0) begin n_fail++; $display("FAIL rmc_clip: got %0d expected 0", clip_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmc_ovf: got %b expected 0", overflow); end
    we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fb_we) we_cnt++;
      if (clear_done) done_cnt++;
      adv();
    end
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rmc_no_writes: got %0d expected 0", we_cnt); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rmc_no_done: got %0d expected 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clip();
    test_backpressure();
    test_random();
    test_clear();
    test_clear_behind();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
